// File: rtl/mips_pkg.sv
// Shared MIPS constants for the memory stage: opcodes, exception codes and
// a small decoder that turns an opcode into memory-access controls.
package mips_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    mem_size_e size;
    logic      sign_ext;
  } mem_ctrl_t;

  function automatic mem_ctrl_t decode_op(input logic [5:0] op);
    mem_ctrl_t c;
    c.is_load  = 1'b0;
    c.is_store = 1'b0;
    c.size     = SZ_WORD;
    c.sign_ext = 1'b0;
    case (op)
      OP_LW:  begin c.is_load  = 1'b1; c.size = SZ_WORD; end
      OP_LB:  begin c.is_load  = 1'b1; c.size = SZ_BYTE; c.sign_ext = 1'b1; end
      OP_LBU: begin c.is_load  = 1'b1; c.size = SZ_BYTE; end
      OP_LH:  begin c.is_load  = 1'b1; c.size = SZ_HALF; c.sign_ext = 1'b1; end
      OP_LHU: begin c.is_load  = 1'b1; c.size = SZ_HALF; end
      OP_SW:  begin c.is_store = 1'b1; c.size = SZ_WORD; end
      OP_SB:  begin c.is_store = 1'b1; c.size = SZ_BYTE; end
      OP_SH:  begin c.is_store = 1'b1; c.size = SZ_HALF; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Word-organised data memory: per-byte write enables, asynchronous
// active-low clear of every word, and combinational read.
module dm_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_BITS   = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [ADDR_BITS-1:0] idx_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: address-error detection, byte/half/word load-store
// against dm_ram, load extension and the M/W pipeline register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_BITS   = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOut_in_M,
  input  logic [31:0] Data_to_dm_in_M,
  input  logic [31:0] Instr_in_M,
  input  logic [31:0] PC4_in_M,
  input  logic [4:0]  WriteReg_in_M,
  input  logic        flush_M,
  output logic        AdE_out_M,
  output logic [31:0] ReadData_out_W,
  output logic [31:0] ALUOut_out_W,
  output logic [31:0] Instr_out_W,
  output logic [31:0] PC4_out_W,
  output logic [4:0]  WriteReg_out_W,
  output logic [4:0]  ExcCode_out_W
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

  mem_ctrl_t   ctrl;
  logic        misalign;
  logic        out_of_range;
  logic        addr_err;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_data;

  logic [31:0] rdata_d,  rdata_q;
  logic [31:0] alu_d,    alu_q;
  logic [31:0] instr_d,  instr_q;
  logic [31:0] pc4_d,    pc4_q;
  logic [4:0]  wreg_d,   wreg_q;
  logic [4:0]  exc_d,    exc_q;

  always_comb begin
    ctrl         = decode_op(Instr_in_M[31:26]);
    out_of_range = (ALUOut_in_M >= MEM_BYTES);
    misalign     = 1'b0;
    case (ctrl.size)
      SZ_WORD: misalign = (ALUOut_in_M[1:0] != 2'b00);
      SZ_HALF: misalign = ALUOut_in_M[0];
      default: misalign = 1'b0;
    endcase
    addr_err  = (ctrl.is_load | ctrl.is_store) & (misalign | out_of_range);
    AdE_out_M = addr_err & ~flush_M;
  end

  // Store data is replicated across lanes; the byte enables pick the target.
  always_comb begin
    dm_we    = ctrl.is_store & ~addr_err & ~flush_M;
    dm_be    = 4'b0000;
    dm_wdata = Data_to_dm_in_M;
    case (ctrl.size)
      SZ_WORD: dm_be = 4'b1111;
      SZ_HALF: begin
        dm_be    = ALUOut_in_M[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{Data_to_dm_in_M[15:0]}};
      end
      SZ_BYTE: begin
        dm_be    = 4'b0001 << ALUOut_in_M[1:0];
        dm_wdata = {4{Data_to_dm_in_M[7:0]}};
      end
      default: dm_be = 4'b0000;
    endcase
  end

  dm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BITS   (ADDR_BITS)
  ) u_dm_ram (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (dm_we),
    .be_i    (dm_be),
    .idx_i   (ALUOut_in_M[ADDR_BITS+1:2]),
    .wdata_i (dm_wdata),
    .rdata_o (dm_rdata)
  );

  always_comb begin
    ld_half = ALUOut_in_M[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld_byte = dm_rdata[8*ALUOut_in_M[1:0] +: 8];
    ld_data = dm_rdata;
    case (ctrl.size)
      SZ_HALF: ld_data = ctrl.sign_ext ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      SZ_BYTE: ld_data = ctrl.sign_ext ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      default: ld_data = dm_rdata;
    endcase
  end

  // Faulting instructions keep Instr/PC4/ALUOut so CP0 can report the EPC.
  always_comb begin
    alu_d   = ALUOut_in_M;
    instr_d = Instr_in_M;
    pc4_d   = PC4_in_M;
    wreg_d  = WriteReg_in_M;
    rdata_d = ctrl.is_load ? ld_data : 32'h0;
    exc_d   = EXC_NONE;
    if (addr_err) begin
      wreg_d  = 5'd0;
      rdata_d = 32'h0;
      exc_d   = ctrl.is_load ? EXC_ADEL : EXC_ADES;
    end
    if (flush_M) begin
      alu_d   = 32'h0;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      wreg_d  = 5'd0;
      rdata_d = 32'h0;
      exc_d   = EXC_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      alu_q   <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      wreg_q  <= '0;
      exc_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      wreg_q  <= wreg_d;
      exc_q   <= exc_d;
    end
  end

  assign ReadData_out_W = rdata_q;
  assign ALUOut_out_W   = alu_q;
  assign Instr_out_W    = instr_q;
  assign PC4_out_W      = pc4_q;
  assign WriteReg_out_W = wreg_q;
  assign ExcCode_out_W  = exc_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory (M) stage of the 5-stage MIPS pipeline, directly downstream of the Execute stage.
- Consumes the E-stage results as latched by the E/M register: ALU address, store data, instruction, PC+4 and destination register.
- Performs word, half and byte loads and stores against an internal word-organised data memory and detects address errors.
- Registers all results into the M/W pipeline register for write-back.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words in data memory; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
ADDR_BITS, 12, log2(DEPTH_WORDS); word index = ALUOut_in_M[ADDR_BITS+1:2].

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low; 0 clears all state.
ALUOut_in_M  input  32  effective address for loads/stores, or ALU result passed through.
Data_to_dm_in_M  input  32  forwarded rt value (store data).
Instr_in_M  input  32  instruction in M.
PC4_in_M  input  32  PC+4 of instruction in M.
WriteReg_in_M  input  5  destination register chosen in E.
flush_M  input  1  1 = instruction in M is squashed: no store, bubble written into M/W.
AdE_out_M  output  1  combinational; 1 = current load/store has an address error.
ReadData_out_W  output  32  extended load data (registered).
ALUOut_out_W  output  32  registered ALUOut_in_M.
Instr_out_W  output  32  registered instruction.
PC4_out_W  output  32  registered PC+4.
WriteReg_out_W  output  5  registered destination; 0 when no write-back.
ExcCode_out_W  output  5  0 = none, 4 = AdEL, 5 = AdES (registered).

Behaviour:
Opcode decode (Instr[31:26]):
- Loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
- Stores: sw 101011, sb 101000, sh 101001.
- Everything else is a non-memory instruction.

Address error, evaluated combinationally on ALUOut_in_M (addr):
- lw/sw with addr[1:0] != 0.
- lh/lhu/sh with addr[0] != 0.
- Any load/store with addr >= 4*DEPTH_WORDS.
- AdE_out_M = error & ~flush_M.

Stores (M-cycle rising edge):
- Write happens only if the instruction is a store, there is no error, flush_M = 0 and reset = 1.
- sw writes the whole word.
- sh writes halfword addr[1]: lower lanes [15:0] when addr[1] = 0, upper lanes [31:16] when addr[1] = 1; data is Data_to_dm_in_M[15:0].
- sb writes byte lane addr[1:0]; data is Data_to_dm_in_M[7:0].
- Untouched lanes keep their value. Little-endian lane numbering.

Loads:
- Word read is combinational from the word index, so it sees any store committed on an earlier edge.
- Byte/halfword is selected by addr[1:0].
- lb/lh sign-extend; lbu/lhu zero-extend.
- Load-use latency is 1: data appears on ReadData_out_W the cycle after the load is in M.

M/W register, updated every rising edge; there is no stall input because M never stalls:
- Normal case: ALUOut, Instr, PC4 and WriteReg are copied from their M inputs; ReadData = extended load data (0 for non-loads); ExcCode = 0.
- On address error: WriteReg_out_W = 0, ReadData_out_W = 0, ExcCode = 4 (load) or 5 (store); Instr/PC4/ALUOut are still copied so CP0 sees the faulting PC.
- On flush_M = 1: all M/W outputs load 0 (bubble), even if an error exists.

Reset:
- reset = 0 immediately forces every M/W output to 0 and clears every memory word to 0.
- A store coincident with reset is not performed.
- Deasserting reset mid-stream: the first edge after release samples M inputs normally.

Simultaneous events:
- A store in M and a load in W never conflict, since W holds already-read data.
- Back-to-back sw then lw to the same address: the lw returns the new value.

Decomposition:
- Shared package mips_pkg holds opcode constants (OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH) and ExcCode constants (EXC_NONE = 0, EXC_ADEL = 4, EXC_ADES = 5).
- One sub-module is natural: dm_ram, the word array with byte-enable write, async active-low clear and combinational read.
- Load extension, error detection and the M/W register stay in mem_stage.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> ReadData_out_W = 0xDEADBEEF one cycle after lw in M; WriteReg passes through.
- Word 0x20 = 0x8000_7F80; lb 0x20 -> 0xFFFFFF80; lbu 0x20 -> 0x00000080; lh 0x22 -> 0xFFFF8000; lhu 0x22 -> 0x00008000.
- sb 0x31 data 0x000000AA over word 0x11223344 -> lw 0x30 = 0x1122AA44; then sh 0x32 data 0x5566 -> lw 0x30 = 0x5566AA44.
- lw 0x41 -> AdE_out_M = 1, ExcCode_out_W = 4, WriteReg_out_W = 0. sh 0x43 -> ExcCode_out_W = 5 and memory unchanged. sw 0x4000 with DEPTH_WORDS = 4096 -> ExcCode 5.
- sw with flush_M = 1 -> memory unchanged, all W outputs 0, AdE_out_M = 0 even for a misaligned address.
- Write word 0x8 = 0x1234, pulse reset low mid-cycle -> all W outputs 0 asynchronously; lw 0x8 after release returns 0.
